// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and helpers for the SPI master arbiter: FSM state encoding,
// default frame width and index-width helper.
package spi_master_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int unsigned DW_DEFAULT = 15;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after rr_ptr (wrapping),
// returned both one-hot and as an index.
module rr_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] win,
    output logic [IW-1:0]    win_idx
);

    always_comb begin
        logic          found;
        int unsigned   cand;
        logic [IW-1:0] cidx;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        cidx    = '0;
        // Offsets 1..N_REQ so the last-served requester is checked last.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(rr_ptr) + k) % N_REQ;
            cidx = IW'(cand);
            if (!found && req[cidx]) begin
                found     = 1'b1;
                win_idx   = cidx;
                win[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin front end sharing one SPI_MASTER frame engine between N_REQ requesters.
// Optional WAIT-state timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = DW_DEFAULT,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] di_flat,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [DW-1:0]       do_out,
    output logic                busy,
    output logic                err,
    output logic                spi_st,
    output logic [DW-1:0]       spi_di,
    input  logic                spi_load,
    input  logic [DW-1:0]       spi_do
);

    localparam int unsigned IW = idx_w(N_REQ);

    arb_state_t        state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     win_idx;
    logic [N_REQ-1:0]  win;
    logic              load_d;
    logic              load_rise;
    logic [DW-1:0]     di_lane [N_REQ];

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     wait_cnt;
`else
    assign err = 1'b0;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_arbiter (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            di_lane[i] = di_flat[i*DW +: DW];
        end
    end

    // load_d tracks LOAD every cycle, so a level already high when START
    // is entered is never seen as an edge in WAIT.
    assign load_rise = spi_load & ~load_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            gnt      <= '0;
            done     <= '0;
            do_out   <= '0;
            busy     <= 1'b0;
            spi_st   <= 1'b0;
            spi_di   <= '0;
            rr_ptr   <= IW'(N_REQ - 1);
            idx      <= '0;
            load_d   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            err      <= 1'b0;
            wait_cnt <= '0;
`endif
        end else begin
            load_d <= spi_load;
            case (state)
                IDLE: begin
                    if (|req) begin
                        idx    <= win_idx;
                        spi_di <= di_lane[win_idx];
                        gnt    <= win;
                        spi_st <= 1'b1;
                        busy   <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    spi_st <= 1'b0;
                    state  <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (load_rise) begin
                        do_out <= spi_do;
                        done   <= gnt;
                        state  <= DONE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        do_out <= '0;
                        done   <= gnt;
                        err    <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    done   <= '0;
                    gnt    <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= idx;
                    state  <= IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                    err    <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
